// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone round-robin arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/wb_watchdog.sv
// Per-access watchdog: counts cycles a strobe waits and flags the last allowed cycle.
module wb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic hit
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT);
  localparam logic [15:0] LAST  = 16'(TIMEOUT - 1);

  logic [15:0] wdt;

  assign hit = run & (wdt == LAST);

  // The hit cycle clears the counter so a still-held strobe starts a fresh window.
  always_ff @(posedge clock) begin
    if (reset || clear || hit) begin
      wdt <= '0;
    end else if (run && (wdt != LIMIT)) begin
      wdt <= wdt + 16'd1;
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone classic arbiter with a per-access watchdog.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_data_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_ack_i,
  output logic [1:0]        grant
);

  arb_state_e state, state_next;
  logic       last, last_next;
  logic       own0, own1, owning;
  logic       sel_stb;
  logic       timeout_hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ARB_IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_next;
      last  <= last_next;
    end
  end

  // last only moves on a tie, so a lone requester never disturbs the rotation.
  always_comb begin
    state_next = state;
    last_next  = last;
    unique case (state)
      ARB_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_next = last ? ARB_OWN0 : ARB_OWN1;
          last_next  = ~last;
        end else if (m0_cyc_i) begin
          state_next = ARB_OWN0;
        end else if (m1_cyc_i) begin
          state_next = ARB_OWN1;
        end
      end
      ARB_OWN0: if (!m0_cyc_i) state_next = ARB_IDLE;
      ARB_OWN1: if (!m1_cyc_i) state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  assign own0   = (state == ARB_OWN0);
  assign own1   = (state == ARB_OWN1);
  assign owning = own0 | own1;

  always_comb begin
    s_cyc_o  = 1'b0;
    sel_stb  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_data_o = '0;
    if (own0) begin
      s_cyc_o  = m0_cyc_i;
      sel_stb  = m0_stb_i;
      s_we_o   = m0_we_i;
      s_addr_o = m0_addr_i;
      s_data_o = m0_data_i;
    end else if (own1) begin
      s_cyc_o  = m1_cyc_i;
      sel_stb  = m1_stb_i;
      s_we_o   = m1_we_i;
      s_addr_o = m1_addr_i;
      s_data_o = m1_data_i;
    end
  end

  wb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clock(clock),
    .reset(reset),
    .clear(~owning | ~sel_stb | s_ack_i),
    .run  (owning & sel_stb & ~s_ack_i),
    .hit  (timeout_hit)
  );

  assign s_stb_o   = sel_stb & ~timeout_hit;
  assign m0_ack_o  = own0 & s_ack_i & ~timeout_hit;
  assign m1_ack_o  = own1 & s_ack_i & ~timeout_hit;
  assign m0_err_o  = own0 & timeout_hit;
  assign m1_err_o  = own1 & timeout_hit;
  assign m0_data_o = own0 ? s_data_i : '0;
  assign m1_data_o = own1 ? s_data_i : '0;
  assign grant     = own0 ? GRANT_M0 : (own1 ? GRANT_M1 : GRANT_NONE);

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Two-master round-robin Wishbone (classic, single-cycle-strobe) arbiter placed between the UART Wishbone master and the `wb_system` slave port. It lets a second master, such as an on-chip ROM loader or self-test sequencer, share the system bus. It registers a grant per bus cycle (`cyc`), muxes the granted master onto the slave, and routes responses back. A per-access watchdog terminates any strobe the slave never acknowledges.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 255, max cycles a strobe waits for `s_ack_i` before `err` is returned (1..65535)

- `clock`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i`  in  1 each  master 0 bus cycle, strobe, write enable
- `m0_addr_i`  in  ADDR_W  master 0 address
- `m0_data_i`  in  DATA_W  master 0 write data
- `m0_data_o`  out  DATA_W  read data to master 0
- `m0_ack_o`, `m0_err_o`  out  1 each  master 0 acknowledge / error
- `m1_*`  same set as `m0_*`  master 1
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  to slave
- `s_addr_o`  out  ADDR_W  to slave
- `s_data_o`  out  DATA_W  write data to slave
- `s_data_i`  in  DATA_W  read data from slave
- `s_ack_i`  in  1  slave acknowledge
- `grant`  out  2  one-hot current owner (`01` = m0, `10` = m1, `00` = idle)

## Operation
- FSM states: IDLE, OWN0, OWN1.
- IDLE:
  - If only one `mN_cyc_i` is high, go to OWNN.
  - If both are high, grant the master that was not `last`, then set `last` to the winner.
  - On reset, `last` is 1, so m0 wins the first tie.
- OWNn:
  - Slave `cyc/stb/we/addr/data` come combinationally from master n.
  - `mn_ack_o = s_ack_i & ~timeout_hit`.
  - `mn_data_o = s_data_i`.
  - The non-granted master sees ack=0, err=0, data=0.
- Leaving OWNn:
  - Go to IDLE on the first cycle `mn_cyc_i` is low.
  - There is always one idle cycle between owners. No same-cycle hand-off.
  - A master holding `cyc` keeps the bus indefinitely (locked sequences allowed).
- Watchdog:
  - `wdt` counter clears when not in OWNn, when `s_stb_o` is low, or when `s_ack_i` is high.
  - Otherwise it increments, saturating at TIMEOUT.
  - `timeout_hit = (wdt == TIMEOUT-1) & s_stb_o & ~s_ack_i`. On that cycle:
    - `mn_err_o` pulses for 1 cycle and `s_stb_o` is forced low.
    - `wdt` clears.
- `s_ack_i` received in IDLE is ignored.
- Simultaneous `s_ack_i` and watchdog expiry: ack wins, err stays 0.

## Timing
- Reset values:
  - State IDLE, `grant=00`, `last=1`, `wdt=0`.
  - All `s_*_o`, `m*_ack_o` and `m*_err_o` are 0. Data outputs are 0.
- Reset mid-transfer aborts immediately. No ack or err is issued for the aborted access.
- Grant latency: `cyc` high at edge k gives `grant` valid and `s_cyc_o` high after edge k+1.
  - A master must hold `stb` until ack or err (Wishbone classic rule).
- Response path is combinational, so the slave ack reaches the master in the same cycle.
- Release: `cyc` low at edge k gives IDLE after k+1. The earliest other-master grant is after k+2.
- Error path: err is asserted `TIMEOUT` cycles after `s_stb_o` rose with no ack.

## Structure
- Package `wb_arb_pkg`: FSM state enum (`ARB_IDLE`, `ARB_OWN0`, `ARB_OWN1`) and grant encoding constants.
- Sub-module `wb_watchdog` (params `TIMEOUT`; ports `clock`, `reset`, `clear`, `run`, `hit`) holds the counter and its saturation logic.
- The arbiter FSM and muxes stay in `wb_rr_arbiter`.

## Test plan
- m0 reads 0x10, slave acks after 3 cycles with 0xCAFEF00D:
  - `grant=01` one cycle after `cyc`.
  - `m0_ack_o` pulses with `m0_data_o=0xCAFEF00D`.
  - m1 sees nothing.
- m0 and m1 raise `cyc` in the same cycle immediately after reset:
  - m0 is granted first.
  - After m0 drops `cyc`, one idle cycle follows, then `grant=10`.
- Repeated simultaneous requests over 6 transactions: grants alternate 01, 10, 01, 10, 01, 10.
- `TIMEOUT=8`, slave never acks m1 write:
  - `m1_err_o` is high exactly on the 8th cycle of `s_stb_o` high.
  - `s_stb_o` is low that cycle. No ack is seen.
- Slave ack coincides with the watchdog-expiry cycle: ack=1, err=0.
- `reset` asserted while in OWN1 with `stb` pending:
  - Next cycle `grant=00` and all `s_*_o` are 0.
  - A following simultaneous request is granted to m0.
